// File: rtl/tl_ul_arb2.sv
// Two-requester TileLink-UL arbiter: round-robin A-channel grant with burst locking,
// and D-channel responses routed back by the source MSB added on the A channel.
module tl_ul_arb2 #(
    parameter int SRC_W = 2
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             a0_valid,
    output logic             a0_ready,
    input  logic [2:0]       a0_opcode,
    input  logic [2:0]       a0_param,
    input  logic [2:0]       a0_size,
    input  logic [SRC_W-1:0] a0_source,
    input  logic [31:0]      a0_address,
    input  logic [3:0]       a0_mask,
    input  logic [31:0]      a0_data,

    input  logic             a1_valid,
    output logic             a1_ready,
    input  logic [2:0]       a1_opcode,
    input  logic [2:0]       a1_param,
    input  logic [2:0]       a1_size,
    input  logic [SRC_W-1:0] a1_source,
    input  logic [31:0]      a1_address,
    input  logic [3:0]       a1_mask,
    input  logic [31:0]      a1_data,

    output logic             a_valid,
    input  logic             a_ready,
    output logic [2:0]       a_opcode,
    output logic [2:0]       a_param,
    output logic [2:0]       a_size,
    output logic [SRC_W:0]   a_source,
    output logic [31:0]      a_address,
    output logic [3:0]       a_mask,
    output logic [31:0]      a_data,

    input  logic             d_valid,
    output logic             d_ready,
    input  logic [2:0]       d_opcode,
    input  logic [1:0]       d_param,
    input  logic [2:0]       d_size,
    input  logic [SRC_W:0]   d_source,
    input  logic [31:0]      d_data,
    input  logic             d_error,

    output logic             d0_valid,
    input  logic             d0_ready,
    output logic [2:0]       d0_opcode,
    output logic [1:0]       d0_param,
    output logic [2:0]       d0_size,
    output logic [SRC_W-1:0] d0_source,
    output logic [31:0]      d0_data,
    output logic             d0_error,

    output logic             d1_valid,
    input  logic             d1_ready,
    output logic [2:0]       d1_opcode,
    output logic [1:0]       d1_param,
    output logic [2:0]       d1_size,
    output logic [SRC_W-1:0] d1_source,
    output logic [31:0]      d1_data,
    output logic             d1_error
);

    typedef enum logic {IDLE, BURST} mode_e;

    mode_e      mode_q, mode_d;
    logic       lock_q, lock_d;
    logic       rr_q, rr_d;
    logic [3:0] remaining_q, remaining_d;

    logic       grant;
    logic       fire;
    logic [4:0] beats;

    // Only full/partial puts larger than one bus word span multiple beats.
    function automatic logic [4:0] calc_beats(input logic [2:0] op, input logic [2:0] sz);
        if ((op == 3'd0 || op == 3'd1) && sz > 3'd2) return 5'd1 << (sz - 3'd2);
        else return 5'd1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= IDLE;
            lock_q      <= 1'b0;
            rr_q        <= 1'b1;
            remaining_q <= 4'd0;
        end else begin
            mode_q      <= mode_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        mode_d      = mode_q;
        lock_d      = lock_q;
        rr_d        = rr_q;
        remaining_d = remaining_q;
        if (fire) begin
            unique case (mode_q)
                IDLE: begin
                    if (beats > 5'd1) begin
                        mode_d      = BURST;
                        lock_d      = grant;
                        remaining_d = 4'(beats - 5'd1);
                    end else begin
                        rr_d = grant;
                    end
                end
                BURST: begin
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        mode_d = IDLE;
                        rr_d   = grant;
                    end
                end
                default: mode_d = IDLE;
            endcase
        end
    end

    // Grant never looks at a_ready, so a_valid stays free of a ready->valid path.
    always_comb begin
        grant = ~rr_q;
        if (mode_q == BURST)        grant = lock_q;
        else if (a0_valid ^ a1_valid) grant = a1_valid;
    end

    always_comb begin
        a_valid   = grant ? a1_valid   : a0_valid;
        a_opcode  = grant ? a1_opcode  : a0_opcode;
        a_param   = grant ? a1_param   : a0_param;
        a_size    = grant ? a1_size    : a0_size;
        a_source  = {grant, (grant ? a1_source : a0_source)};
        a_address = grant ? a1_address : a0_address;
        a_mask    = grant ? a1_mask    : a0_mask;
        a_data    = grant ? a1_data    : a0_data;
        a0_ready  = ~grant & a_ready;
        a1_ready  =  grant & a_ready;
        fire      = a_valid & a_ready;
        beats     = calc_beats(a_opcode, a_size);
    end

    always_comb begin
        d0_valid  = d_valid & ~d_source[SRC_W];
        d1_valid  = d_valid &  d_source[SRC_W];
        d_ready   = d_source[SRC_W] ? d1_ready : d0_ready;
        d0_opcode = d_opcode;
        d1_opcode = d_opcode;
        d0_param  = d_param;
        d1_param  = d_param;
        d0_size   = d_size;
        d1_size   = d_size;
        d0_source = d_source[SRC_W-1:0];
        d1_source = d_source[SRC_W-1:0];
        d0_data   = d_data;
        d1_data   = d_data;
        d0_error  = d_error;
        d1_error  = d_error;
    end

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Self-checking bench for tl_ul_arb2: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the arbitration rules.
module tb_tl_ul_arb2;

    localparam int SRC_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;

    logic             a0_valid, a0_ready;
    logic [2:0]       a0_opcode, a0_param, a0_size;
    logic [SRC_W-1:0] a0_source;
    logic [31:0]      a0_address, a0_data;
    logic [3:0]       a0_mask;

    logic             a1_valid, a1_ready;
    logic [2:0]       a1_opcode, a1_param, a1_size;
    logic [SRC_W-1:0] a1_source;
    logic [31:0]      a1_address, a1_data;
    logic [3:0]       a1_mask;

    logic             a_valid, a_ready;
    logic [2:0]       a_opcode, a_param, a_size;
    logic [SRC_W:0]   a_source;
    logic [31:0]      a_address, a_data;
    logic [3:0]       a_mask;

    logic             d_valid, d_ready;
    logic [2:0]       d_opcode, d_size;
    logic [1:0]       d_param;
    logic [SRC_W:0]   d_source;
    logic [31:0]      d_data;
    logic             d_error;

    logic             d0_valid, d0_ready, d0_error;
    logic [2:0]       d0_opcode, d0_size;
    logic [1:0]       d0_param;
    logic [SRC_W-1:0] d0_source;
    logic [31:0]      d0_data;

    logic             d1_valid, d1_ready, d1_error;
    logic [2:0]       d1_opcode, d1_size;
    logic [1:0]       d1_param;
    logic [SRC_W-1:0] d1_source;
    logic [31:0]      d1_data;

    tl_ul_arb2 #(.SRC_W(SRC_W)) dut (
        .clock(clock), .reset(reset),
        .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_param(a0_param),
        .a0_size(a0_size), .a0_source(a0_source), .a0_address(a0_address), .a0_mask(a0_mask),
        .a0_data(a0_data),
        .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_param(a1_param),
        .a1_size(a1_size), .a1_source(a1_source), .a1_address(a1_address), .a1_mask(a1_mask),
        .a1_data(a1_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_error(d_error),
        .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_opcode(d0_opcode), .d0_param(d0_param),
        .d0_size(d0_size), .d0_source(d0_source), .d0_data(d0_data), .d0_error(d0_error),
        .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_opcode(d1_opcode), .d1_param(d1_param),
        .d1_size(d1_size), .d1_source(d1_source), .d1_data(d1_data), .d1_error(d1_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: beats still owed by the current burst owner, and last winner.
    int m_left  = 0;
    int m_owner = 0;
    int m_last  = 1;

    int obs_grant;
    int fire_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_beats(input logic [2:0] op, input logic [2:0] sz);
        if ((op == 3'd0 || op == 3'd1) && sz > 3'd2) return 2 ** (int'(sz) - 2);
        return 1;
    endfunction

    task automatic idle_inputs();
        a0_valid = 0; a0_opcode = 0; a0_param = 0; a0_size = 0; a0_source = 0;
        a0_address = 0; a0_mask = 0; a0_data = 0;
        a1_valid = 0; a1_opcode = 0; a1_param = 0; a1_size = 0; a1_source = 0;
        a1_address = 0; a1_mask = 0; a1_data = 0;
        a_ready = 0; d_valid = 0; d_opcode = 0; d_param = 0; d_size = 0;
        d_source = 0; d_data = 0; d_error = 0; d0_ready = 0; d1_ready = 0;
    endtask

    task automatic set_req(input int port, input logic v, input logic [2:0] op, input logic [2:0] sz);
        if (port == 0) begin
            a0_valid = v; a0_opcode = op; a0_size = sz; a0_param = 3'($urandom);
            a0_source = SRC_W'($urandom); a0_address = $urandom; a0_mask = 4'($urandom);
            a0_data = $urandom;
        end else begin
            a1_valid = v; a1_opcode = op; a1_size = sz; a1_param = 3'($urandom);
            a1_source = SRC_W'($urandom); a1_address = $urandom; a1_mask = 4'($urandom);
            a1_data = $urandom;
        end
    endtask

    // Called just after a falling edge with inputs settled; checks, updates model, moves on.
    task automatic run_cycle();
        int g, p, n;
        logic ev, ef;
        #1;
        if (m_left > 0) g = m_owner;
        else if (a0_valid && !a1_valid) g = 0;
        else if (a1_valid && !a0_valid) g = 1;
        else g = 1 - m_last;
        ev = (g == 1) ? a1_valid : a0_valid;
        check("a_valid", a_valid, ev);
        check("a_grant", a_source[SRC_W], g);
        check("a_src_low", a_source[SRC_W-1:0], (g == 1) ? a1_source : a0_source);
        check("a_fields", {a_opcode, a_param, a_size, a_mask},
              (g == 1) ? {a1_opcode, a1_param, a1_size, a1_mask} : {a0_opcode, a0_param, a0_size, a0_mask});
        check("a_addr_data", {a_address, a_data},
              (g == 1) ? {a1_address, a1_data} : {a0_address, a0_data});
        check("a0_ready", a0_ready, (g == 0) ? a_ready : 1'b0);
        check("a1_ready", a1_ready, (g == 1) ? a_ready : 1'b0);
        p = int'(d_source[SRC_W]);
        check("d0_valid", d0_valid, (p == 0) ? d_valid : 1'b0);
        check("d1_valid", d1_valid, (p == 1) ? d_valid : 1'b0);
        check("d_ready", d_ready, (p == 1) ? d1_ready : d0_ready);
        check("d_src", {d0_source, d1_source}, {d_source[SRC_W-1:0], d_source[SRC_W-1:0]});
        check("d0_bcast", {d0_opcode, d0_param, d0_size, d0_error, d0_data},
              {d_opcode, d_param, d_size, d_error, d_data});
        check("d1_bcast", {d1_opcode, d1_param, d1_size, d1_error, d1_data},
              {d_opcode, d_param, d_size, d_error, d_data});
        obs_grant = int'(a_source[SRC_W]);
        if (a_valid && a_ready) fire_cnt++;
        ef = ev & a_ready;
        if (ef) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_last = m_owner;
            end else begin
                n = (g == 1) ? model_beats(a1_opcode, a1_size) : model_beats(a0_opcode, a0_size);
                if (n > 1) begin
                    m_left  = n - 1;
                    m_owner = g;
                end else begin
                    m_last = g;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        #1;
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_d_ready", d_ready, 1'b0);
        check("rst_a_ready", {a0_ready, a1_ready}, 2'b00);
        check("rst_d_valid", {d0_valid, d1_valid}, 2'b00);
        m_left = 0; m_owner = 0; m_last = 1;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        #2;
        apply_reset();

        // Single-beat Gets from both sides alternate starting at port 0.
        a_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 3'd4, 3'd2);
            set_req(1, 1, 3'd4, 3'd2);
            run_cycle();
            check("alt_grant", obs_grant, i % 2);
        end

        // Four-beat put from port 0 holds off port 1 until done.
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1, 3'd0, 3'd4);
            set_req(1, 1, 3'd4, 3'd2);
            run_cycle();
            check("burst_grant", obs_grant, (i < 4) ? 0 : 1);
        end

        // Burst with ready stalls and a valid bubble: still exactly four port-0 beats.
        fire_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            set_req(0, (i != 4), 3'd1, 3'd4);
            set_req(1, 1, 3'd4, 3'd2);
            a_ready = (i != 1 && i != 2);
            run_cycle();
            check("stall_grant", obs_grant, 0);
        end
        check("stall_fires", fire_cnt, 4);
        a_ready = 1;
        set_req(0, 1, 3'd4, 3'd2);
        set_req(1, 1, 3'd4, 3'd2);
        run_cycle();
        check("after_stall_grant", obs_grant, 1);

        // D routing to port 1 with backpressure.
        idle_inputs();
        d_valid = 1; d_source = {1'b1, 2'b10}; d_data = 32'hcafe_f00d; d_opcode = 3'd1;
        d1_ready = 0; d0_ready = 1;
        run_cycle();
        check("d_route_bp", {d1_valid, d0_valid, d1_source, d_ready}, {1'b1, 1'b0, 2'b10, 1'b0});
        d_valid = 1; d_source = {1'b1, 2'b10}; d1_ready = 1; d0_ready = 0;
        run_cycle();
        check("d_route_go", {d1_valid, d0_valid, d1_source, d_ready}, {1'b1, 1'b0, 2'b10, 1'b1});

        // Reset in the middle of a port-1 burst abandons it; port 0 wins next contention.
        apply_reset();
        a_ready = 1;
        for (int i = 0; i < 2; i++) begin
            set_req(1, 1, 3'd0, 3'd4);
            run_cycle();
            check("pre_rst_grant", obs_grant, 1);
        end
        apply_reset();
        a_ready = 1;
        set_req(0, 1, 3'd4, 3'd2);
        set_req(1, 1, 3'd4, 3'd2);
        run_cycle();
        check("post_rst_grant", obs_grant, 0);

        // Randomized traffic on both channels.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd3};
            set_req(0, ($urandom_range(0, 3) != 0), ops[$urandom_range(0, 4)], 3'($urandom_range(0, 6)));
            set_req(1, ($urandom_range(0, 3) != 0), ops[$urandom_range(0, 4)], 3'($urandom_range(0, 6)));
            a_ready  = ($urandom_range(0, 3) != 0);
            d_valid  = 1'($urandom);
            d_source = 3'($urandom);
            d_opcode = 3'($urandom);
            d_param  = 2'($urandom);
            d_size   = 3'($urandom);
            d_data   = $urandom;
            d_error  = 1'($urandom);
            d0_ready = 1'($urandom);
            d1_ready = 1'($urandom);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
